// File: rtl/cmd_engine_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cmd_engine_pkg
// Purpose  : Shared opcodes, response characters and FSM state encoding
//            for the cmd_engine host command parser.
// Revision : 1.0  initial release
// ============================================================================
package cmd_engine_pkg;

  // Host opcodes
  localparam logic [7:0] OP_SET    = 8'h01;
  localparam logic [7:0] OP_PROC   = 8'h02;
  localparam logic [7:0] OP_RET    = 8'h03;
  localparam logic [7:0] OP_TEST   = 8'h04;
  localparam logic [7:0] OP_STATUS = 8'h05;

  // Response characters
  localparam logic [7:0] ACK_CHAR  = 8'h01;
  localparam logic [7:0] NACK_CHAR = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SET_HASH  = 4'd1,
    ST_PROC_LEN  = 4'd2,
    ST_PROC_DATA = 4'd3,
    ST_PROC_WAIT = 4'd4,
    ST_RET_POS   = 4'd5,
    ST_RET_STR   = 4'd6,
    ST_TEST      = 4'd7,
    ST_STATUS    = 4'd8,
    ST_TX_WAIT   = 4'd9,
    ST_ACK       = 4'd10,
    ST_NACK      = 4'd11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cmd_engine_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tx_byte_seq
// Purpose  : One-byte transmit handshake towards uart_tx. While send is high
//            and the transmitter is idle, the byte is registered onto
//            txd_data together with a one-cycle txd_start; done tells the
//            caller the byte was accepted this cycle.
// Ports    : clk, reset        clock / async active-high reset
//            send, tx_byte     request and byte from the command FSM
//            txd_busy          transmitter busy
//            done              byte accepted (combinational)
//            txd_start         one-cycle transmit request (registered)
//            txd_data          byte to transmit (registered)
// Revision : 1.0  initial release
// ============================================================================
module tx_byte_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] tx_byte,
  input  logic       txd_busy,
  output logic       done,
  output logic       txd_start,
  output logic [7:0] txd_data
);

  logic       r_txd_start;
  logic [7:0] r_txd_data;

  assign done = send & ~txd_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txd_start <= 1'b0;
      r_txd_data  <= 8'h00;
    end else begin
      r_txd_start <= done;
      if (done) r_txd_data <= tx_byte;
    end
  end

  assign txd_start = r_txd_start;
  assign txd_data  = r_txd_data;

endmodule
`default_nettype wire

// File: rtl/cmd_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cmd_engine
// Purpose  : Byte-stream command engine between uart_rx/uart_tx and the md5
//            search core. Parses SET / PROC / RET / TEST / STATUS opcodes,
//            drives the process interface and answers with ACK/NACK.
// Ports    : clk, reset                      clock / async active-high reset
//            rxd_data, rxd_data_ready        received byte + strobe
//            txd_busy, txd_start, txd_data   transmit handshake
//            proc_*                          hash core process interface
//            led                             state code LSBs
// Revision : 1.0  initial release
// ============================================================================
module cmd_engine
  import cmd_engine_pkg::*;
#(
  parameter int NUM_LEDS       = 8,
  parameter int HASH_BYTES     = 16,
  parameter int LEN_BYTES      = 2,
  parameter int MATCH_LEN      = 19,
  parameter int TEST_COUNT     = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rxd_data,
  input  logic                    rxd_data_ready,
  input  logic                    txd_busy,
  output logic                    txd_start,
  output logic [7:0]              txd_data,
  input  logic                    proc_done,
  input  logic                    proc_match,
  input  logic [8*LEN_BYTES-1:0]  proc_byte_pos,
  input  logic [7:0]              proc_match_char,
  output logic                    proc_start,
  output logic                    proc_abort,
  output logic [8*LEN_BYTES-1:0]  proc_num_bytes,
  output logic [7:0]              proc_data,
  output logic                    proc_data_valid,
  output logic                    proc_match_char_next,
  output logic [8*HASH_BYTES-1:0] proc_target_hash,
  output logic [NUM_LEDS-1:0]     led
);

  localparam int c_nw    = 8*LEN_BYTES;
  localparam int c_hw    = 8*HASH_BYTES;
  localparam int c_cw    = 8*LEN_BYTES + 1;
  localparam int c_tw    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [c_cw-1:0] c_hash_last  = c_cw'(HASH_BYTES - 1);
  localparam logic [c_cw-1:0] c_len_last   = c_cw'(LEN_BYTES - 1);
  localparam logic [c_cw-1:0] c_match_last = c_cw'(MATCH_LEN - 1);
  localparam logic [c_cw-1:0] c_test_last  = c_cw'(TEST_COUNT - 1);
  localparam logic [7:0]      c_test_count = 8'(TEST_COUNT);
  localparam logic [c_tw-1:0] c_tmo_last   = c_tw'(TIMEOUT_CYCLES - 1);

  state_t            r_state, r_ret_state;
  state_t            w_state_next, w_ret_next;
  logic [c_cw-1:0]   r_cnt;
  logic [c_cw-1:0]   w_cnt_inc;
  logic [c_tw-1:0]   r_timer;
  logic [c_nw-1:0]   r_num_bytes, r_pos_shift, w_len_next;
  logic [c_hw-1:0]   r_target_hash;
  logic [7:0]        r_proc_data;
  logic              r_proc_data_valid, r_proc_start, r_proc_abort, r_char_next;
  logic              r_last_done, r_last_match;
  logic              w_send, w_done, w_start, w_abort, w_char_next, w_timed, w_tmo;
  logic [7:0]        w_tx_byte;

  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_len_next = (r_num_bytes << 8) | c_nw'(rxd_data);
  assign w_timed    = (r_state == ST_SET_HASH) || (r_state == ST_PROC_LEN) ||
                      (r_state == ST_PROC_DATA);
  // A byte arriving in the same cycle as the last timer tick wins.
  assign w_tmo      = (r_timer == c_tmo_last) && !rxd_data_ready;

  tx_byte_seq u_tx (
    .clk       (clk),
    .reset     (reset),
    .send      (w_send),
    .tx_byte   (w_tx_byte),
    .txd_busy  (txd_busy),
    .done      (w_done),
    .txd_start (txd_start),
    .txd_data  (txd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ret_state <= ST_IDLE;
    end else begin
      r_state     <= w_state_next;
      r_ret_state <= w_ret_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ret_next   = r_ret_state;
    w_send       = 1'b0;
    w_tx_byte    = 8'h00;
    w_start      = 1'b0;
    w_abort      = 1'b0;
    w_char_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rxd_data_ready) begin
          case (rxd_data)
            OP_SET:    w_state_next = ST_SET_HASH;
            OP_PROC:   w_state_next = ST_PROC_LEN;
            OP_RET:    w_state_next = ST_RET_POS;
            OP_TEST:   w_state_next = ST_TEST;
            OP_STATUS: w_state_next = ST_STATUS;
            default:   w_state_next = ST_NACK;
          endcase
        end
      end
      ST_SET_HASH: begin
        if (rxd_data_ready && r_cnt == c_hash_last) w_state_next = ST_ACK;
        else if (w_tmo)                             w_state_next = ST_NACK;
      end
      ST_PROC_LEN: begin
        if (rxd_data_ready && r_cnt == c_len_last) begin
          w_start      = (w_len_next != '0);
          w_state_next = w_start ? ST_PROC_DATA : ST_NACK;
        end else if (w_tmo) begin
          w_state_next = ST_NACK;
        end
      end
      ST_PROC_DATA: begin
        if (rxd_data_ready && w_cnt_inc == {1'b0, r_num_bytes}) begin
          w_state_next = ST_PROC_WAIT;
        end else if (w_tmo) begin
          w_state_next = ST_NACK;
          w_abort      = 1'b1;
        end
      end
      ST_PROC_WAIT: begin
        if (proc_done) w_state_next = proc_match ? ST_ACK : ST_NACK;
      end
      ST_RET_POS: begin
        w_send    = 1'b1;
        w_tx_byte = r_pos_shift[c_nw-1 -: 8];
        if (w_done) begin
          w_state_next = ST_TX_WAIT;
          w_ret_next   = (r_cnt == c_len_last) ? ST_RET_STR : ST_RET_POS;
        end
      end
      ST_RET_STR: begin
        w_send      = 1'b1;
        w_tx_byte   = proc_match_char;
        w_char_next = w_done;
        if (w_done) begin
          w_state_next = ST_TX_WAIT;
          w_ret_next   = (r_cnt == c_match_last) ? ST_IDLE : ST_RET_STR;
        end
      end
      ST_TEST: begin
        w_send    = 1'b1;
        w_tx_byte = c_test_count - r_cnt[7:0];
        if (w_done) begin
          w_state_next = ST_TX_WAIT;
          w_ret_next   = (r_cnt == c_test_last) ? ST_IDLE : ST_TEST;
        end
      end
      ST_STATUS, ST_ACK, ST_NACK: begin
        w_send    = 1'b1;
        w_tx_byte = (r_state == ST_ACK)  ? ACK_CHAR :
                    (r_state == ST_NACK) ? NACK_CHAR :
                    {6'b0, r_last_match, r_last_done};
        if (w_done) begin
          w_state_next = ST_TX_WAIT;
          w_ret_next   = ST_IDLE;
        end
      end
      ST_TX_WAIT: begin
        if (txd_busy) w_state_next = r_ret_state;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt             <= '0;
      r_timer           <= '0;
      r_num_bytes       <= '0;
      r_pos_shift       <= '0;
      r_target_hash     <= '0;
      r_proc_data       <= 8'h00;
      r_proc_data_valid <= 1'b0;
      r_proc_start      <= 1'b0;
      r_proc_abort      <= 1'b0;
      r_char_next       <= 1'b0;
      r_last_done       <= 1'b0;
      r_last_match      <= 1'b0;
    end else begin
      r_proc_start      <= w_start;
      r_proc_abort      <= w_abort;
      r_char_next       <= w_char_next;
      r_proc_data_valid <= (r_state == ST_PROC_DATA) && rxd_data_ready;
      r_timer <= (w_timed && !rxd_data_ready && w_state_next == r_state) ?
                 r_timer + 1'b1 : '0;

      if (w_start) begin
        r_last_done  <= 1'b0;
        r_last_match <= 1'b0;
      end else if (proc_done) begin
        r_last_done  <= 1'b1;
        r_last_match <= proc_match;
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt       <= '0;
          r_pos_shift <= proc_byte_pos;
        end
        ST_SET_HASH, ST_PROC_LEN, ST_PROC_DATA: begin
          if (rxd_data_ready) begin
            r_cnt <= (w_state_next != r_state) ? '0 : w_cnt_inc;
            if (r_state == ST_SET_HASH)
              r_target_hash <= (r_target_hash << 8) | c_hw'(rxd_data);
            if (r_state == ST_PROC_LEN)
              r_num_bytes <= w_len_next;
            if (r_state == ST_PROC_DATA)
              r_proc_data <= rxd_data;
          end
        end
        ST_RET_POS, ST_RET_STR, ST_TEST: begin
          if (w_done) begin
            r_cnt <= (w_ret_next != r_state) ? '0 : w_cnt_inc;
            if (r_state == ST_RET_POS) r_pos_shift <= r_pos_shift << 8;
          end
        end
        default: ;
      endcase
    end
  end

  assign proc_start           = r_proc_start;
  assign proc_abort           = r_proc_abort;
  assign proc_num_bytes       = r_num_bytes;
  assign proc_data            = r_proc_data;
  assign proc_data_valid      = r_proc_data_valid;
  assign proc_match_char_next = r_char_next;
  assign proc_target_hash     = r_target_hash;
  assign led                  = NUM_LEDS'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_cmd_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cmd_engine
// Purpose  : Self-checking bench for cmd_engine: directed command sequence
//            plus randomized SET/PROC payloads checked against a behavioural
//            model of the host protocol.
// Revision : 1.0  initial release
// ============================================================================
module tb_cmd_engine;
  import cmd_engine_pkg::*;

  localparam int TO = 100;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   rxd_data = 8'h00;
  logic         rxd_data_ready = 1'b0;
  logic         txd_busy = 1'b0;
  logic         txd_start;
  logic [7:0]   txd_data;
  logic         proc_done = 1'b0;
  logic         proc_match = 1'b0;
  logic [15:0]  proc_byte_pos = 16'h0000;
  logic [7:0]   proc_match_char = 8'hA0;
  logic         proc_start, proc_abort, proc_data_valid, proc_match_char_next;
  logic [15:0]  proc_num_bytes;
  logic [7:0]   proc_data;
  logic [127:0] proc_target_hash;
  logic [7:0]   led;

  cmd_engine #(.NUM_LEDS(8), .HASH_BYTES(16), .LEN_BYTES(2), .MATCH_LEN(19),
               .TEST_COUNT(10), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rxd_data(rxd_data), .rxd_data_ready(rxd_data_ready),
    .txd_busy(txd_busy), .txd_start(txd_start), .txd_data(txd_data),
    .proc_done(proc_done), .proc_match(proc_match), .proc_byte_pos(proc_byte_pos),
    .proc_match_char(proc_match_char), .proc_start(proc_start), .proc_abort(proc_abort),
    .proc_num_bytes(proc_num_bytes), .proc_data(proc_data),
    .proc_data_valid(proc_data_valid), .proc_match_char_next(proc_match_char_next),
    .proc_target_hash(proc_target_hash), .led(led));

  initial forever #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int start_cnt = 0, abort_cnt = 0, abort_cyc = 0, next_cnt = 0, extra_starts = 0;
  int busy_left = 0, busy_len = 3, match_idx = 0, last_rx_cyc = 0;
  logic [7:0]   tx_q[$], data_q[$], exp_q[$], in_q[$];
  logic [127:0] m_hash = '0;
  logic         m_done = 1'b0, m_match = 1'b0;

  // Transmitter / hash-core responder and output monitor
  initial forever begin
    @(negedge clk);
    cyc++;
    if (txd_start) begin
      if (txd_busy) extra_starts++;
      tx_q.push_back(txd_data);
    end
    if (proc_match_char_next) begin next_cnt++; match_idx++; end
    if (proc_start) start_cnt++;
    if (proc_abort) begin abort_cnt++; abort_cyc = cyc; end
    if (proc_data_valid) data_q.push_back(proc_data);
    if (txd_start) begin
      txd_busy  = 1'b1;
      busy_left = busy_len;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) txd_busy = 1'b0;
    end
    proc_match_char = 8'hA0 + 8'(match_idx);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rxd_data = b; rxd_data_ready = 1'b1; last_rx_cyc = cyc;
    @(negedge clk);
    rxd_data_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_tx(input string tag);
    int n = exp_q.size();
    int i = 0;
    while (tx_q.size() < n && i < 5000) begin @(negedge clk); i++; end
    repeat (busy_len + 10) @(negedge clk);
    check({tag, "_len"}, tx_q.size(), n);
    for (int k = 0; k < n; k++)
      check($sformatf("%s_b%0d", tag, k), (k < tx_q.size()) ? tx_q[k] : 8'hxx, exp_q[k]);
    tx_q.delete(); exp_q.delete();
  endtask

  task automatic do_status(input string tag);
    exp_q.push_back({6'b0, m_match, m_done});
    send_rx(OP_STATUS);
    expect_tx(tag);
  endtask

  // Sends a PROC command carrying every byte in in_q; the core must see only
  // the first len of them.
  task automatic run_proc(input logic [15:0] len, input logic match, input string tag);
    int s0 = start_cnt;
    data_q.delete();
    send_rx(OP_PROC); send_rx(len[15:8]); send_rx(len[7:0]);
    foreach (in_q[k]) send_rx(in_q[k]);
    repeat (4) @(negedge clk);
    if (len == 16'd0) begin
      check({tag, "_nostart"}, start_cnt - s0, 0);
      exp_q.push_back(NACK_CHAR);
      expect_tx(tag);
      return;
    end
    check({tag, "_start"}, start_cnt - s0, 1);
    check({tag, "_nbytes"}, proc_num_bytes, len);
    check({tag, "_ndata"}, data_q.size(), len);
    for (int k = 0; k < int'(len); k++)
      check($sformatf("%s_d%0d", tag, k), (k < data_q.size()) ? data_q[k] : 8'hxx, in_q[k]);
    @(negedge clk); proc_done = 1'b1; proc_match = match;
    @(negedge clk); proc_done = 1'b0; proc_match = 1'b0;
    m_done = 1'b1; m_match = match;
    exp_q.push_back(match ? ACK_CHAR : NACK_CHAR);
    expect_tx(tag);
  endtask

  initial begin
    int a0, d;
    logic [15:0] rl;
    logic rm;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd_start", txd_start, 0);
    check("rst_txd_data", txd_data, 8'h00);
    check("rst_proc_start", proc_start, 0);
    check("rst_proc_abort", proc_abort, 0);
    check("rst_valid", proc_data_valid, 0);
    check("rst_char_next", proc_match_char_next, 0);
    check("rst_proc_data", proc_data, 0);
    check("rst_num_bytes", proc_num_bytes, 0);
    check("rst_hash", proc_target_hash, 0);
    check("rst_led", led, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // SET with 0x00..0x0F
    send_rx(OP_SET);
    for (int k = 0; k < 16; k++) begin
      send_rx(8'(k));
      m_hash = (m_hash << 8) | 128'(k);
    end
    exp_q.push_back(ACK_CHAR);
    expect_tx("set_dir");
    check("set_dir_hash", proc_target_hash, 128'h000102030405060708090A0B0C0D0E0F);

    // SET with random bytes
    send_rx(OP_SET);
    for (int k = 0; k < 16; k++) begin
      logic [7:0] b = 8'($urandom);
      send_rx(b);
      m_hash = (m_hash << 8) | 128'(b);
    end
    exp_q.push_back(ACK_CHAR);
    expect_tx("set_rnd");
    check("set_rnd_hash", proc_target_hash, m_hash);

    // PROC "abc" matched, then unmatched
    in_q = '{8'h61, 8'h62, 8'h63};
    run_proc(16'd3, 1'b1, "proc_abc_m");
    do_status("status_m");
    run_proc(16'd3, 1'b0, "proc_abc_n");
    do_status("status_n");

    // Zero-length guard
    in_q.delete();
    run_proc(16'd0, 1'b0, "proc_zero");

    // Random PROC runs; the last one carries a surplus byte that must be dropped
    for (int r = 0; r < 3; r++) begin
      rl = 16'($urandom_range(1, 6));
      rm = 1'($urandom);
      in_q.delete();
      for (int k = 0; k < int'(rl) + (r == 2 ? 1 : 0); k++) in_q.push_back(8'($urandom));
      run_proc(rl, rm, $sformatf("proc_rnd%0d", r));
    end
    do_status("status_rnd");

    // Timeout mid-PROC: length 5, two bytes, then silence
    a0 = abort_cnt;
    data_q.delete();
    send_rx(OP_PROC); send_rx(8'h00); send_rx(8'h05);
    send_rx(8'h11); send_rx(8'h22);
    d = last_rx_cyc;
    exp_q.push_back(NACK_CHAR);
    expect_tx("tmo_proc");
    check("tmo_abort_cnt", abort_cnt - a0, 1);
    check("tmo_abort_time", (abort_cyc - d >= TO - 5) && (abort_cyc - d <= TO + 10), 1);
    check("tmo_idle_led", led, 0);
    m_done = 1'b0; m_match = 1'b0;
    do_status("status_tmo");

    // Timeout mid-SET keeps the partially shifted hash
    a0 = abort_cnt;
    send_rx(OP_SET);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] b = 8'($urandom);
      send_rx(b);
      m_hash = (m_hash << 8) | 128'(b);
    end
    exp_q.push_back(NACK_CHAR);
    expect_tx("tmo_set");
    check("tmo_set_hash", proc_target_hash, m_hash);
    check("tmo_set_noabort", abort_cnt - a0, 0);

    // RET with a slow transmitter
    busy_len = 50; proc_byte_pos = 16'h1234; match_idx = 0; next_cnt = 0;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    for (int k = 0; k < 19; k++) exp_q.push_back(8'hA0 + 8'(k));
    send_rx(OP_RET);
    expect_tx("ret");
    check("ret_next_cnt", next_cnt, 19);
    check("ret_extra_start", extra_starts, 0);
    busy_len = 3;

    // Unknown opcode
    exp_q.push_back(NACK_CHAR);
    send_rx(8'h7F);
    expect_tx("unknown_op");

    // TEST countdown
    for (int k = 10; k >= 1; k--) exp_q.push_back(8'(k));
    send_rx(OP_TEST);
    expect_tx("test");

    // Reset mid-command aborts silently
    send_rx(OP_SET); send_rx(8'hAA);
    #2 reset = 1'b1;
    @(negedge clk);
    check("midrst_hash", proc_target_hash, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_notx", tx_q.size(), 0);
    check("midrst_led", led, 0);
    m_done = 1'b0; m_match = 1'b0;
    do_status("status_rst");

    check("extra_starts", extra_starts, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
